// File: rtl/gmii_rx_deframer.sv
// GMII receive deframer: strips preamble/SFD, checks FCS, length and rx_er, forwards payload bytes.
// Optional destination-MAC filter is compiled in when RX_MAC_FILTER_EN is defined.
module gmii_rx_deframer #(
  parameter int          MIN_FRAME = 64,
  parameter int          MAX_FRAME = 1518,
  parameter int          CNT_W     = 16,
  parameter logic [47:0] LOCAL_MAC = 48'h000A35000001
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_error,
  output logic             frame_ok,
  output logic             frame_bad,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] bad_count
);

  localparam int               LEN_W    = $clog2(MAX_FRAME + 2);
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] LEN_DLY  = LEN_W'(5);
  localparam logic [31:0]      CRC_INIT = 32'hFFFFFFFF;
  localparam logic [31:0]      CRC_RES  = 32'hDEBB20E3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]       st_q, st_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [4:0][7:0]  dl_q, dl_d;
  logic             er_q, er_d;
  logic [7:0]       mdat_q, mdat_d;
  logic             mval_q, mval_d, mlast_q, mlast_d, merr_q, merr_d;
  logic             fok_q, fok_d, fbad_q, fbad_d;
  logic [CNT_W-1:0] okc_q, okc_d, badc_q, badc_d;
  logic             fwd_live, fwd_end, frame_err;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

`ifdef RX_MAC_FILTER_EN
  // Running match flags for unicast-to-us and broadcast over the first 6 DATA bytes.
  logic        loc_q, bc_q, loc_nxt, bc_nxt, in_hdr;
  logic [47:0] mac_sh;

  always_comb begin
    in_hdr   = (len_q < LEN_W'(6));
    mac_sh   = LOCAL_MAC >> {3'd5 - len_q[2:0], 3'b000};
    loc_nxt  = loc_q & (!in_hdr | (gmii_rxd == mac_sh[7:0]));
    bc_nxt   = bc_q  & (!in_hdr | (gmii_rxd == 8'hFF));
    fwd_live = loc_nxt | bc_nxt;
    fwd_end  = loc_q | bc_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loc_q <= 1'b0;
      bc_q  <= 1'b0;
    end else if (st_q != S_DATA) begin
      loc_q <= 1'b1;
      bc_q  <= 1'b1;
    end else if (gmii_rx_dv) begin
      loc_q <= loc_nxt;
      bc_q  <= bc_nxt;
    end
  end
`else
  logic unused_mac;
  assign unused_mac = ^LOCAL_MAC;
  assign fwd_live   = 1'b1;
  assign fwd_end    = 1'b1;
`endif

  always_comb begin
    st_d    = st_q;
    crc_d   = crc_q;
    len_d   = len_q;
    dl_d    = dl_q;
    er_d    = er_q;
    mdat_d  = mdat_q;
    mval_d  = 1'b0;
    mlast_d = 1'b0;
    merr_d  = 1'b0;
    fok_d   = 1'b0;
    fbad_d  = 1'b0;
    okc_d   = okc_q;
    badc_d  = badc_q;
    frame_err = (crc_q != CRC_RES) | er_q | (len_q < LEN_MIN) | (len_q > LEN_MAX);

    case (st_q)
      S_IDLE:
        if (gmii_rx_dv) begin
          if (gmii_rxd == 8'h55)      st_d = S_PRE;
          else if (gmii_rxd == 8'hD5) st_d = S_DATA;
          else                        st_d = S_DROP;
        end
      S_PRE:
        if (!gmii_rx_dv)            st_d = S_IDLE;
        else if (gmii_rxd == 8'hD5) st_d = S_DATA;
        else if (gmii_rxd != 8'h55) st_d = S_DROP;
      S_DATA:
        if (gmii_rx_dv) begin
          crc_d = crc_byte(crc_q, gmii_rxd);
          dl_d  = {dl_q[3:0], gmii_rxd};
          er_d  = er_q | gmii_rx_er;
          if (len_q != LEN_SAT) len_d = len_q + 1'b1;
          // Once 5 bytes are buffered, each new byte releases the oldest one.
          if (len_q >= LEN_DLY && fwd_live) begin
            mval_d = 1'b1;
            mdat_d = dl_q[4];
          end
        end else begin
          st_d = S_IDLE;
          if (fwd_end) begin
            if (len_q >= LEN_DLY) begin
              mval_d  = 1'b1;
              mlast_d = 1'b1;
              mdat_d  = dl_q[4];
              merr_d  = frame_err;
            end
            fok_d  = !frame_err;
            fbad_d = frame_err;
            if (!frame_err && !(&okc_q)) okc_d  = okc_q + 1'b1;
            if (frame_err && !(&badc_q)) badc_d = badc_q + 1'b1;
          end
        end
      default:
        if (!gmii_rx_dv) st_d = S_IDLE;
    endcase

    if (st_d == S_DATA && st_q != S_DATA) begin
      crc_d = CRC_INIT;
      len_d = '0;
      er_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_DROP;
      crc_q   <= CRC_INIT;
      len_q   <= '0;
      dl_q    <= '0;
      er_q    <= 1'b0;
      mdat_q  <= '0;
      mval_q  <= 1'b0;
      mlast_q <= 1'b0;
      merr_q  <= 1'b0;
      fok_q   <= 1'b0;
      fbad_q  <= 1'b0;
      okc_q   <= '0;
      badc_q  <= '0;
    end else begin
      st_q    <= st_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
      dl_q    <= dl_d;
      er_q    <= er_d;
      mdat_q  <= mdat_d;
      mval_q  <= mval_d;
      mlast_q <= mlast_d;
      merr_q  <= merr_d;
      fok_q   <= fok_d;
      fbad_q  <= fbad_d;
      okc_q   <= okc_d;
      badc_q  <= badc_d;
    end
  end

  assign m_data    = mdat_q;
  assign m_valid   = mval_q;
  assign m_last    = mlast_q;
  assign m_error   = merr_q;
  assign frame_ok  = fok_q;
  assign frame_bad = fbad_q;
  assign ok_count  = okc_q;
  assign bad_count = badc_q;

endmodule

// File: tb/tb_gmii_rx_deframer.sv
// Directed bench for gmii_rx_deframer: frame-level model builds expected beats and frame events.
module tb_gmii_rx_deframer;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv, gmii_rx_er;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_error, frame_ok, frame_bad;
  logic [15:0] ok_count, bad_count;

  gmii_rx_deframer dut (
    .clock(clock), .reset_n(reset_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_error(m_error), .frame_ok(frame_ok), .frame_bad(frame_bad),
    .ok_count(ok_count), .bad_count(bad_count)
  );

  always #4 clock = ~clock;

  typedef struct packed { logic [7:0] d; logic last; logic err; } beat_t;

  beat_t      exp_q[$];
  bit         evt_q[$];
  logic [7:0] frm[$];
  int         er_at, ncmp, nerr, nbeats, nbadp, mok, mbad;
  logic       gap_er;
  beat_t      cb;
  bit         ce;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Ethernet CRC-32 (reflected, init all-ones, final inversion) over frm[0..n-1].
  function automatic logic [31:0] crc32(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if (c[0] ^ frm[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                  c = c >> 1;
    return ~c;
  endfunction

  // plen content bytes (dest MAC 00:0A:35:00:00:01 first), plus FCS when addfcs.
  task automatic build(input int plen, input int seed, input bit addfcs);
    logic [47:0] mac;
    logic [31:0] c;
    mac = 48'h000A35000001;
    frm.delete();
    for (int i = 0; i < plen; i++)
      if (i < 6) frm.push_back(mac[47-8*i -: 8]);
      else       frm.push_back(8'((seed + i * 13) & 255));
    if (addfcs) begin
      c = crc32(plen);
      frm.push_back(c[7:0]);  frm.push_back(c[15:8]);
      frm.push_back(c[23:16]); frm.push_back(c[31:24]);
    end
  endtask

  // Model: payload is everything but the trailing 4 FCS bytes; frame bad on FCS, rx_er, length.
  task automatic expect_frame();
    int  n;
    bit  bad;
    n   = frm.size();
    bad = (n < 64) || (n > 1518) || (er_at >= 0);
    if (n >= 4) bad = bad || (crc32(n - 4) != {frm[n-1], frm[n-2], frm[n-3], frm[n-4]});
    else        bad = 1'b1;
    for (int i = 0; i + 4 < n; i++)
      exp_q.push_back('{d: frm[i], last: (i == n - 5), err: bad});
    evt_q.push_back(!bad);
    if (bad) mbad++; else mok++;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d, input logic er);
    @(negedge clock);
    gmii_rx_dv = dv; gmii_rxd = d; gmii_rx_er = er;
  endtask

  task automatic send(input int npre, input int gap);
    expect_frame();
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, frm[i], i == er_at);
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, gap_er);
  endtask

  task automatic settle(input string nm);
    repeat (12) @(negedge clock);
    chk({nm, " beats drained"}, exp_q.size(), 0);
    chk({nm, " events drained"}, evt_q.size(), 0);
    chk({nm, " ok_count"}, ok_count, mok);
    chk({nm, " bad_count"}, bad_count, mbad);
    exp_q.delete(); evt_q.delete();
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (m_valid) begin
        nbeats++;
        if (exp_q.size() == 0) chk("unexpected beat", m_valid, 0);
        else begin
          cb = exp_q.pop_front();
          chk("beat data", m_data, cb.d);
          chk("beat last", m_last, cb.last);
          if (cb.last) begin
            chk("beat error", m_error, cb.err);
            chk("end pulse with m_last", frame_ok | frame_bad, 1);
          end
        end
      end
      if (frame_ok || frame_bad) begin
        if (frame_bad) nbadp++;
        if (evt_q.size() == 0) chk("unexpected frame pulse", frame_ok | frame_bad, 0);
        else begin
          ce = evt_q.pop_front();
          chk("frame_ok", frame_ok, ce);
          chk("frame_bad", frame_bad, !ce);
        end
      end
    end
  end

  initial begin
    string s;
    reset_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
    er_at = -1; gap_er = 1'b0; ncmp = 0; nerr = 0; nbeats = 0; nbadp = 0; mok = 0; mbad = 0;

    s = "123456789";
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(s[i]);
    chk("crc32 check value", crc32(9), 32'hCBF43926);

    repeat (2) @(negedge clock);
    chk("reset m_valid", m_valid, 0);
    chk("reset m_last", m_last, 0);
    chk("reset m_error", m_error, 0);
    chk("reset m_data", m_data, 0);
    chk("reset frame_ok", frame_ok, 0);
    chk("reset frame_bad", frame_bad, 0);
    chk("reset ok_count", ok_count, 0);
    chk("reset bad_count", bad_count, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // good 64-byte frame
    nbeats = 0; build(60, 1, 1); send(7, 1); settle("good64");
    chk("good64 beats", nbeats, 60);
    chk("good64 ok_count literal", ok_count, 1);

    // one payload bit flipped
    nbeats = 0; build(60, 1, 1); frm[10] = frm[10] ^ 8'h04; send(7, 1); settle("bitflip");
    chk("bitflip beats", nbeats, 60);
    chk("bitflip bad_count literal", bad_count, 1);

    // rx_er inside DATA, then a 20-byte runt
    er_at = 20; build(60, 2, 1); send(7, 1); er_at = -1; settle("rx_er");
    nbeats = 0; build(16, 3, 1); send(7, 1); settle("runt20");
    chk("runt20 beats", nbeats, 16);

    // 5-byte frame: one beat, flagged
    nbeats = 0; build(1, 4, 1); send(7, 1); settle("len5");
    chk("len5 beats", nbeats, 1);

    // reset mid-frame, released while dv=1
    build(60, 5, 1);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, frm[i], 1'b0);
    reset_n = 1'b0; mok = 0; mbad = 0;
    drive(1'b1, frm[4], 1'b0);
    chk("midreset m_valid", m_valid, 0);
    chk("midreset ok_count", ok_count, 0);
    drive(1'b1, frm[5], 1'b0);
    reset_n = 1'b1;
    for (int i = 6; i < frm.size(); i++) drive(1'b1, frm[i], 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    settle("midreset tail");
    build(60, 6, 1); send(7, 1); settle("after reset");
    chk("after reset ok_count literal", ok_count, 1);
    chk("after reset bad_count literal", bad_count, 0);

    // back-to-back frames with 1-cycle gap, then a 3-byte frame
    nbeats = 0;
    build(60, 7, 1); send(7, 1);
    build(70, 8, 1); send(7, 1);
    settle("b2b");
    chk("b2b beats", nbeats, 130);
    nbeats = 0; nbadp = 0; build(3, 9, 0); send(7, 1); settle("len3");
    chk("len3 beats", nbeats, 0);
    chk("len3 frame_bad pulses", nbadp, 1);

    // SFD without preamble; rx_er during the dv=0 gap must be ignored
    gap_er = 1'b1; build(60, 10, 1); send(0, 3); gap_er = 1'b0; settle("nopre");

    // preamble broken by garbage, then preamble-only burst: nothing forwarded
    nbeats = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h12, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, (i % 2) ? 8'hD5 : 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    settle("garbage");
    chk("garbage beats", nbeats, 0);

    // length boundaries: 1518 good, 1519 oversize
    build(1514, 11, 1); send(7, 1); settle("max1518");
    build(1515, 12, 1); send(7, 1); settle("over1519");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
